// File: rtl/regfile_bypass_sb_if.sv
// Register file bus: writeback, read/issue request and registered results.
// master = pipeline side (drives requests), slave = register file.
interface regfile_bypass_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            RegWrite;
  logic [AW-1:0]   wr;
  logic [XLEN-1:0] wd;
  logic            ReadEn;
  logic [AW-1:0]   rr1;
  logic [AW-1:0]   rr2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            IssueValid;
  logic [AW-1:0]   IssueRd;
  logic            busy1;
  logic            busy2;

  modport master (
    output RegWrite, wr, wd, ReadEn, rr1, rr2,
    output IssueValid, IssueRd,
    input  rd1, rd2, busy1, busy2
  );

  modport slave (
    input  RegWrite, wr, wd, ReadEn, rr1, rr2,
    input  IssueValid, IssueRd,
    output rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// 2R/1W register file with write->read bypass, read hold and busy scoreboard.
// Ports: clk, rst (sync, active-high), bus (slave side of regfile_bypass_sb_if).
module regfile_bypass_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned INIT_IDX = 5,
  parameter int unsigned INIT_VAL = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_bypass_sb_if.slave bus
);
  localparam int unsigned NREGS = 2 ** AW;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  rd1_q, rd1_d;
  logic [XLEN-1:0]  rd2_q, rd2_d;
  logic             busy1_q, busy1_d;
  logic             busy2_q, busy2_d;

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = bus.RegWrite &&
                  !(ZERO_REG && bus.wr == '0);
  assign iss_ok = bus.IssueValid &&
                  !(ZERO_REG && bus.IssueRd == '0);

  function automatic logic [XLEN-1:0] rd_val(
    input logic [AW-1:0] idx
  );
    if (ZERO_REG && idx == '0)
      return '0;
    else if (wr_ok && bus.wr == idx)
      return bus.wd;
    else
      return regs_q[idx];
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_ok)
      regs_d[bus.wr] = bus.wd;
  end

  // Set after clear so a new producer wins over a completing one.
  always_comb begin
    busy_d = busy_q;
    if (bus.RegWrite)
      busy_d[bus.wr] = 1'b0;
    if (iss_ok)
      busy_d[bus.IssueRd] = 1'b1;
  end

  // Busy flags report the post-edge scoreboard state.
  always_comb begin
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    busy1_d = busy1_q;
    busy2_d = busy2_q;
    if (bus.ReadEn) begin
      rd1_d   = rd_val(bus.rr1);
      rd2_d   = rd_val(bus.rr2);
      busy1_d = busy_d[bus.rr1];
      busy2_d = busy_d[bus.rr2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == INIT_IDX) ? XLEN'(INIT_VAL) : '0;
      busy_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      busy1_q <= busy1_d;
      busy2_q <= busy2_d;
    end
  end

  assign bus.rd1   = rd1_q;
  assign bus.rd2   = rd2_q;
  assign bus.busy1 = busy1_q;
  assign bus.busy2 = busy2_q;
endmodule
